// File: rtl/pending_encoder8_3_if.sv
// Handshake bundle for pending_encoder8_3: request lines in, encoded index out.
// master = request source / consumer side, slave = the encoder itself.
interface pending_encoder8_3_if #(
    parameter int N_IN   = 8,
    parameter int CODE_W = 3
);
    logic [N_IN-1:0]   in;
    logic              enable;
    logic              ready;
    logic              valid;
    logic [CODE_W-1:0] code;
    logic [CODE_W:0]   pend_count;
    logic              overflow;

    modport master (
        output in, enable, ready,
        input  valid, code, pend_count, overflow
    );

    modport slave (
        input  in, enable, ready,
        output valid, code, pend_count, overflow
    );
endinterface

// File: rtl/pending_encoder8_3.sv
// pending_encoder8_3: latches request lines into a sticky pending register and
// hands out one encoded index per valid/ready handshake.
// Optional macro ROUND_ROBIN_EN: rotating-start search instead of fixed
// highest-index priority (adds a ptr register).
module pending_encoder8_3 #(
    parameter int N_IN   = 8,
    parameter int CODE_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pending_encoder8_3_if.slave  bus
);

    logic [N_IN-1:0]   pending;
    logic              overflow_q;
    logic [CODE_W-1:0] sel;
    logic [CODE_W:0]   cnt;
    logic              valid_w;
    logic              pop;
    logic [N_IN-1:0]   clr;
    logic [N_IN-1:0]   set;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] ptr;
    logic [CODE_W-1:0] idx;
    logic              found;

    // Search from ptr upwards with wrap; first pending line wins.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            idx = ptr + CODE_W'(k);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: ascending scan, so the highest pending index is kept.
    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (pending[k]) begin
                sel = CODE_W'(k);
            end
        end
    end
`endif

    // Population count of the pending register.
    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            cnt = cnt + (CODE_W+1)'(pending[k]);
        end
    end

    // Pop/clear and new-request masks for the next-state update.
    always_comb begin
        valid_w = |pending;
        pop     = valid_w & bus.ready;
        clr     = pop ? (N_IN'(1) << sel) : '0;
        set     = bus.enable ? bus.in : '0;
    end

    // Pending/overflow state; a set on a line being cleared wins and is not
    // an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | set;
            if (|(set & pending & ~clr)) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    // Advance the search start past the line just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (pop) begin
            ptr <= sel + CODE_W'(1);
        end
    end
`endif

    assign bus.valid      = valid_w;
    assign bus.code       = sel;
    assign bus.pend_count = cnt;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Directed-vector bench for pending_encoder8_3 (fixed priority by default,
// round-robin expectations when ROUND_ROBIN_EN is defined).
module tb_pending_encoder8_3;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] in;
        logic       rdy;
        logic       v;
        logic [2:0] code_fx;
        logic [2:0] code_rr;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tv[$];

    pending_encoder8_3_if #(.N_IN(8), .CODE_W(3)) bus ();

    pending_encoder8_3 #(.N_IN(8), .CODE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [7:0] i, input logic rd,
                       input logic v, input logic [2:0] cf, input logic [2:0] cr,
                       input logic [3:0] c, input logic o);
        vec_t t;
        t.rst = r; t.en = e; t.in = i; t.rdy = rd;
        t.v = v; t.code_fx = cf; t.code_rr = cr; t.cnt = c; t.ovf = o;
        tv.push_back(t);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] i, input logic rd);
        rst = r; bus.enable = e; bus.in = i; bus.ready = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; bus.enable = 1'b1; bus.in = '0; bus.ready = 1'b0;

        //  rst en  in     rdy  v  cfx cRR cnt ovf   (outputs after the edge)
        add(1, 1, 8'hFF, 0,   0, 0, 0, 0, 0);   // reset, requests ignored
        add(1, 1, 8'hFF, 0,   0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0,   0, 0, 0, 0, 0);   // idle
        add(0, 1, 8'h00, 0,   0, 0, 0, 0, 0);
        add(0, 1, 8'h92, 1,   1, 7, 1, 3, 0);   // priority drain, ready while empty ignored
        add(0, 1, 8'h00, 1,   1, 4, 4, 2, 0);
        add(0, 1, 8'h00, 1,   1, 1, 7, 1, 0);
        add(0, 1, 8'h00, 1,   0, 0, 0, 0, 0);
        add(0, 1, 8'h08, 0,   1, 3, 3, 1, 0);   // handshake hold
        add(0, 1, 8'h00, 0,   1, 3, 3, 1, 0);
        add(0, 1, 8'h00, 0,   1, 3, 3, 1, 0);
        add(0, 1, 8'h00, 0,   1, 3, 3, 1, 0);
        add(0, 1, 8'h00, 0,   1, 3, 3, 1, 0);
        add(0, 1, 8'h00, 1,   0, 0, 0, 0, 0);
        add(0, 0, 8'hFF, 0,   0, 0, 0, 0, 0);   // enable gate
        add(0, 0, 8'hFF, 0,   0, 0, 0, 0, 0);
        add(0, 0, 8'hFF, 0,   0, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 0,   1, 7, 4, 8, 0);   // full
        add(0, 1, 8'hFF, 0,   1, 7, 4, 8, 1);   // request on full -> overflow only
        add(1, 1, 8'h00, 0,   0, 0, 0, 0, 0);
        add(0, 1, 8'h04, 0,   1, 2, 2, 1, 0);   // overflow
        add(0, 1, 8'h04, 0,   1, 2, 2, 1, 1);
        add(1, 1, 8'h00, 0,   0, 0, 0, 0, 0);
        add(0, 1, 8'h04, 0,   1, 2, 2, 1, 0);   // set wins over clear
        add(0, 1, 8'h04, 1,   1, 2, 2, 1, 0);
        add(0, 1, 8'h00, 1,   0, 0, 0, 0, 0);
        add(0, 1, 8'h5B, 0,   1, 6, 3, 5, 0);   // mid-op reset
        add(1, 1, 8'hFF, 1,   0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0,   0, 0, 0, 0, 0);

        @(negedge clk);
        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].en, tv[i].in, tv[i].rdy);
            chk("valid",      i, int'(bus.valid),      int'(tv[i].v));
            chk("code",       i, int'(bus.code),       int'(RR ? tv[i].code_rr : tv[i].code_fx));
            chk("pend_count", i, int'(bus.pend_count), int'(tv[i].cnt));
            chk("overflow",   i, int'(bus.overflow),   int'(tv[i].ovf));
        end

        // Level-held single line: same code re-presented every cycle, no overflow.
        step(1, 1, 8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 8'h04, 1);
            chk("hold_code", k, int'(bus.code), 2);
            chk("hold_valid", k, int'(bus.valid), 1);
        end
        chk("hold_ovf", 0, int'(bus.overflow), 0);

        // Level-held pair: fixed priority starves line 0, round-robin alternates.
        step(1, 1, 8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 8'h81, 1);
            chk("pair_code", k, int'(bus.code), RR ? ((k % 2 == 0) ? 0 : 7) : 7);
            chk("pair_cnt", k, int'(bus.pend_count), 2);
        end
        chk("pair_ovf", 0, int'(bus.overflow), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pending_encoder8_3.md
Name: pending_encoder8_3

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 one-hot decoder.
- Latches up to 8 request lines into a sticky pending register.
- Presents the binary index of the selected pending line on a valid/ready handshake and clears that line when the consumer accepts it.
- Sits between request sources (lab peripherals, button/event lines) and a consumer that services one event per handshake.

Parameters:
- N_IN, 8: number of request lines; must equal 2**CODE_W.
- CODE_W, 3: width of the encoded index.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in  input  N_IN  request lines, sampled each clock; level or pulse
- enable  input  1  when 0, `in` is ignored (nothing new latched); pending bits and handshake still operate
- ready  input  1  consumer accepts `code` this cycle
- valid  output  1  at least one line pending
- code  output  CODE_W  index of selected pending line
- pend_count  output  CODE_W+1  number of pending lines (0..N_IN)
- overflow  output  1  sticky: a request hit a line that was already pending

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - rst has priority over all other inputs.
- State:
  - pending[N_IN-1:0]
  - overflow reg
  - ptr[CODE_W-1:0] (ROUND_ROBIN_EN only)
- Reset values: pending=0, valid=0, code=0, pend_count=0, overflow=0, ptr=0.
- Output derivation:
  - valid, code and pend_count are decoded from registered state only; there is no combinational path from in/enable/ready to any output.
  - valid = |pending.
  - pend_count = popcount(pending).
  - code = selected index; code=0 when valid=0.
- Selection, default: fixed priority, highest index wins. pending=8'b0010_0101 -> code=5.
- Pop:
  - Occurs when valid && ready at a rising edge.
  - clr = onehot(code).
  - ready while valid=0 is ignored.
- Update each edge: pending <= (pending & ~clr) | (enable ? in : 0).
- Latency:
  - A request sampled at edge N gives valid/code after edge N (one cycle).
  - After a pop at edge N, the next code is visible after edge N.
  - Back-to-back pops, one per cycle, are supported.
- Simultaneous set and clear on the same bit: set wins. The line stays pending and overflow is not raised.
- Overflow:
  - Set when enable && in[i] && pending[i] && !clr[i], for any i.
  - Sticky until rst.
  - The request is not counted twice.
- Level-held inputs: a line held high with enable=1 re-pends every cycle. After a pop the same code reappears on the next cycle.
- Full (all 8 pending): pend_count=8. Further requests only raise overflow.
- Empty: valid=0, code=0, pend_count=0.
- Reset mid-operation: all pending requests are discarded. Any in/ready in the reset cycle is ignored.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined:
  - Search starts at ptr and ascends with wrap: ptr, ptr+1, ..., ptr+N_IN-1 mod N_IN. First pending wins.
  - On pop, ptr <= code+1 mod N_IN (7 wraps to 0).
  - ptr is unchanged when there is no pop.
- Undefined: fixed highest-index priority. No ptr register is built.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with in=8'hFF -> valid=0, code=0, pend_count=0, overflow=0. Release rst, then in=0 -> stays idle.
- Priority drain: pulse in=8'b1001_0010 one cycle, enable=1, ready=1 continuously.
  - Fixed: codes 7,4,1 on consecutive cycles, then valid=0.
  - ROUND_ROBIN_EN: codes 1,4,7.
- Handshake hold: pulse in=8'h08, ready=0 for 5 cycles -> code=3, valid=1 held stable. ready=1 one cycle -> valid=0 next cycle.
- Enable gate: enable=0, in=8'hFF for 3 cycles -> valid=0. enable=1, one pulse in=8'hFF -> pend_count=8.
- Overflow and set-wins:
  - pending=8'h04, pulse in=8'h04 with ready=0 -> overflow=1.
  - Separately: pending=8'h04, ready=1, in=8'h04 same cycle -> still pending, overflow=0.
- Round-robin fairness (ROUND_ROBIN_EN): hold in=8'h81 with ready=1 -> codes alternate 0,7,0,7.
- Mid-op reset: 5 lines pending, rst=1 one cycle -> all outputs at reset values on the next cycle.
